// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame constants and byte type
package ps2_pkg;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic PS2_START = 1'b0;
  localparam logic PS2_STOP = 1'b1;
  typedef logic [7:0] ps2_byte_t;
endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: scan-code byte FIFO with wrap-bit pointers and sticky overflow
module ps2_sync_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW = 3
) (
  input  logic      clk,
  input  logic      clr,
  input  logic      push_i,
  input  logic      pop_i,
  input  ps2_byte_t din_i,
  output ps2_byte_t dout_o,
  output logic      empty_o,
  output logic      full_o,
  output logic      overflow_o
);
  localparam int DEPTH = 2 ** FIFO_AW;
  ps2_byte_t mem_q [DEPTH];
  logic [FIFO_AW:0] wptr_q, rptr_q;
  logic overflow_q, do_push, do_pop;
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) && (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  // a pop frees the slot in the same cycle, so a push into a full FIFO is accepted then
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o = empty_o ? '0 : mem_q[rptr_q[FIFO_AW-1:0]];
  assign overflow_o = overflow_q;
  always_ff @(posedge clk) begin
    if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q <= do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= do_pop ? rptr_q + 1'b1 : rptr_q;
      overflow_q <= overflow_q | (push_i && !do_push);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[FIFO_AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 frame receiver and byte FIFO; PS2_RX_TIMEOUT_EN adds partial-frame timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic      clk,
  input  logic      clr,
  input  logic      ps2_clk,
  input  logic      ps2_data,
  input  logic      nextdata_n,
  output ps2_byte_t data,
  output logic      ready,
  output logic      overflow,
  output logic      frame_err
);
  logic [2:0] ps2c_q;
  logic [1:0] ps2d_q;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] frame_q, frame_d;
  logic frame_err_q, frame_err_d;
  logic fall, bit_in, last, good, push, empty, timeout;
  assign fall = ps2c_q[2] & ~ps2c_q[1];
  assign bit_in = ps2d_q[1];
  assign last = fall && (cnt_q == 4'(PS2_FRAME_BITS - 1));
  assign good = (frame_q[0] == PS2_START) && (bit_in == PS2_STOP) && (^frame_q[9:1]);
  assign push = last && good;
  always_comb begin
    cnt_d = last ? 4'd0 : fall ? cnt_q + 4'd1 : timeout ? 4'd0 : cnt_q;
    frame_d = (fall && !last) ? {bit_in, frame_q[9:1]} : frame_q;
    frame_err_d = last && !good;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      ps2c_q <= '1;
      ps2d_q <= '1;
      cnt_q <= '0;
      frame_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      ps2c_q <= {ps2c_q[1:0], ps2_clk};
      ps2d_q <= {ps2d_q[0], ps2_data};
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      frame_err_q <= frame_err_d;
    end
  end
`ifdef PS2_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q;
  assign timeout = idle_q == IDLE_W'(TIMEOUT_CYC);
  always_ff @(posedge clk) begin
    if (clr || fall || timeout || cnt_q == 4'd0) idle_q <= '0;
    else idle_q <= idle_q + 1'b1;
  end
`else
  assign timeout = TIMEOUT_CYC < 0;
`endif
  ps2_sync_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push_i    (push),
    .pop_i     (!nextdata_n),
    .din_i     (frame_q[8:1]),
    .dout_o    (data),
    .empty_o   (empty),
    .full_o    (),
    .overflow_o(overflow)
  );
  assign ready = !empty;
  assign frame_err = frame_err_q;
endmodule
